// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, the register-address type and the
// highest-index-wins port selector used by regfile_sb and regfile_scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int NWR_DEF   = 2;

    // Widest port-hit vector the selector accepts; NWR must not exceed this.
    localparam int MAX_PORTS = 32;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

    // Index of the highest set bit of hits (0 when none is set). Later ports
    // overwrite earlier ones, so the highest-indexed matching port wins.
    function automatic int hi_port(input logic [MAX_PORTS-1:0] hits);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (hits[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: write-pending busy vector for regfile_sb.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   iss_valid, iss_rd   issue strobe and destination (marks busy)
//   wr_en, wr_addr      writeback ports (clear busy on commit)
//   busy                registered busy vector, bit 0 always 0
//   busy_cnt            registered popcount of busy
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = NWR_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    output logic [NREGS-1:0]  busy,
    output logic [AW:0]       busy_cnt
);

    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;
    logic [AW:0]      busy_cnt_reg;
    logic [AW:0]      busy_cnt_next;

    assign busy_next[0] = 1'b0;

    genvar gi, gj;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [NWR-1:0] clr_hit;
            logic           set;
            for (gj = 0; gj < NWR; gj++) begin : g_port
                assign clr_hit[gj] = wr_en[gj] && (wr_addr[gj*AW +: AW] == AW'(gi));
            end
            assign set = iss_valid && (iss_rd == AW'(gi));
            // A new producer supersedes a committing one: set beats clear.
            assign busy_next[gi] = set ? 1'b1 : ((|clr_hit) ? 1'b0 : busy_reg[gi]);
        end
    endgenerate

    // Count from the next vector so busy_cnt lines up with busy after each edge.
    always_comb begin
        busy_cnt_next = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy_cnt_next = busy_cnt_next + {{AW{1'b0}}, busy_next[r]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg     <= '0;
            busy_cnt_reg <= '0;
        end else begin
            busy_reg     <= busy_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign busy     = busy_reg;
    assign busy_cnt = busy_cnt_reg;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port integer register file with write-pending scoreboard.
// Register 0 reads zero, ignores writes and is never busy.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rd_addr/rd_data     NRD combinational read ports (port k at [k*W +: W])
//   rd_busy             per read port: addressed register has a pending write
//   wr_en/wr_addr/wr_data  NWR writeback ports, highest index wins on collision
//   iss_valid, iss_rd   issue strobe marking iss_rd busy
//   busy_cnt            registered count of busy registers
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writeback data
// to the read ports and mask rd_busy for the forwarded register.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int NWR   = NWR_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic [AW:0]         busy_cnt
);

    localparam int PW = (NWR > 1) ? $clog2(NWR) : 1;

    logic [XLEN-1:0]  mem_reg   [NREGS];
    logic [XLEN-1:0]  wdata_arr [NWR];
    logic [AW-1:0]    waddr_arr [NWR];
    logic [NWR-1:0]   wr_hit    [NREGS];
    logic [PW-1:0]    wr_sel    [NREGS];
    logic [NREGS-1:0] busy;

    genvar gi, gj;
    generate
        for (gj = 0; gj < NWR; gj++) begin : g_wport
            assign wdata_arr[gj] = wr_data[gj*XLEN +: XLEN];
            assign waddr_arr[gj] = wr_addr[gj*AW +: AW];
        end

        for (gi = 0; gi < NREGS; gi++) begin : g_whit
            for (gj = 0; gj < NWR; gj++) begin : g_port
                assign wr_hit[gi][gj] = (gi != 0) && wr_en[gj] && (waddr_arr[gj] == AW'(gi));
            end
            assign wr_sel[gi] = PW'(hi_port(MAX_PORTS'(wr_hit[gi])));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) mem_reg[r] <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (|wr_hit[r]) mem_reg[r] <= wdata_arr[wr_sel[r]];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rport
            logic [AW-1:0]   raddr;
            logic [XLEN-1:0] rdata;
            logic            rbusy;
            assign raddr = rd_addr[gi*AW +: AW];
`ifdef REGFILE_BYPASS_EN
            logic [NWR-1:0] byp_hit;
            logic [PW-1:0]  byp_sel;
            for (gj = 0; gj < NWR; gj++) begin : g_byp
                assign byp_hit[gj] = wr_en[gj] && (waddr_arr[gj] == raddr) && (raddr != '0);
            end
            assign byp_sel = PW'(hi_port(MAX_PORTS'(byp_hit)));
            always_comb begin
                rdata = (raddr == '0) ? '0 : mem_reg[raddr];
                rbusy = busy[raddr];
                if (|byp_hit) begin
                    rdata = wdata_arr[byp_sel];
                    rbusy = 1'b0;
                end
            end
`else
            always_comb begin
                rdata = (raddr == '0) ? '0 : mem_reg[raddr];
                rbusy = busy[raddr];
            end
`endif
            assign rd_data[gi*XLEN +: XLEN] = rdata;
            assign rd_busy[gi]              = rbusy;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb (default sizes).
// Expected values follow the REGFILE_BYPASS_EN setting of the build.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic          clk;
    logic          rst_n;
    logic [9:0]    rd_addr;
    logic [63:0]   rd_data;
    logic [1:0]    rd_busy;
    logic [1:0]    wr_en;
    logic [9:0]    wr_addr;
    logic [63:0]   wr_data;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic [AW:0]   busy_cnt;

    int n_cmp;
    int n_err;
    logic [31:0] exp_busy;

    regfile_sb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one rising edge and step 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en     = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        idle();

        // Reset state
        #2;
        rd_addr = {5'd31, 5'd5};
        #1;
        check_eq("rst_rd0", rd_data[31:0], 0);
        check_eq("rst_rd1", rd_data[63:32], 0);
        check_eq("rst_busy", rd_busy, 0);
        check_eq("rst_cnt", busy_cnt, 0);
        #4 rst_n = 1'b1;   // t=7, between edges
        tick();

        // x5 = DEADBEEF together with an issue of x5, then async reset mid-cycle
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        iss_valid = 1'b1; iss_rd = 5'd5;
        tick();
        idle();
        rd_addr = {5'd0, 5'd5};
        #1;
        check_eq("x5_written", rd_data[31:0], 32'hDEADBEEF);
        check_eq("x5_busy", rd_busy[0], 1);
        check_eq("cnt_before_rst", busy_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("x5_after_rst", rd_data[31:0], 0);
        check_eq("busy_after_rst", rd_busy[0], 0);
        check_eq("cnt_after_rst", busy_cnt, 0);
        #1 rst_n = 1'b1;
        tick();

        // Write collision on x7: port 1 wins
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22222222, 32'h11111111};
        rd_addr = {5'd0, 5'd7};
        #1;
`ifdef REGFILE_BYPASS_EN
        check_eq("x7_same_cycle", rd_data[31:0], 32'h22222222);
`else
        check_eq("x7_same_cycle", rd_data[31:0], 0);
`endif
        tick();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h1};
        #1;
        check_eq("x7_collision", rd_data[31:0], 32'h22222222);
        tick();
        idle();
        rd_addr = {5'd7, 5'd0};
        #1;
        check_eq("x0_ignores_write", rd_data[31:0], 0);
        check_eq("x7_port1", rd_data[63:32], 32'h22222222);

        // Scoreboard: issue x3, x4, x3
        iss_valid = 1'b1; iss_rd = 5'd3; tick();
        check_eq("cnt_iss_x3", busy_cnt, 1);
        iss_rd = 5'd4; tick();
        check_eq("cnt_iss_x4", busy_cnt, 2);
        iss_rd = 5'd3; tick();
        check_eq("cnt_reiss_x3", busy_cnt, 2);
        idle();
        rd_addr = {5'd4, 5'd3};
        #1;
        check_eq("busy_x3_x4", rd_busy, 2'b11);
        // Commit x3
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h33};
        tick();
        idle();
        #1;
        check_eq("cnt_wr_x3", busy_cnt, 1);
        check_eq("busy_x3_clr", rd_busy[0], 0);
        check_eq("data_x3", rd_data[31:0], 32'h33);
        // Same-cycle issue and write of x4: stays busy, data commits
        wr_en = 2'b10; wr_addr = {5'd4, 5'd0}; wr_data = {32'h44, 32'h0};
        iss_valid = 1'b1; iss_rd = 5'd4;
        tick();
        idle();
        #1;
        check_eq("cnt_iss_wr_x4", busy_cnt, 1);
        check_eq("busy_x4_held", rd_busy[1], 1);
        check_eq("data_x4", rd_data[63:32], 32'h44);

        // Bypass: x9 busy, then written while being read
        iss_valid = 1'b1; iss_rd = 5'd9; tick();
        idle();
        check_eq("cnt_iss_x9", busy_cnt, 2);
        rd_addr = {5'd4, 5'd9};
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'hCAFE0001};
        #1;
`ifdef REGFILE_BYPASS_EN
        check_eq("x9_bypass_data", rd_data[31:0], 32'hCAFE0001);
        check_eq("x9_bypass_busy", rd_busy[0], 0);
`else
        check_eq("x9_old_data", rd_data[31:0], 0);
        check_eq("x9_busy_persists", rd_busy[0], 1);
`endif
        check_eq("x4_unaffected", rd_busy[1], 1);
        tick();
        idle();
        #1;
        check_eq("x9_committed", rd_data[31:0], 32'hCAFE0001);
        check_eq("x9_busy_clr", rd_busy[0], 0);
        check_eq("cnt_wr_x9", busy_cnt, 1);

        // Full scoreboard: issue x1..x31 (x4 already busy)
        exp_busy = 32'h10;
        for (int k = 1; k < 32; k++) begin
            iss_valid = 1'b1; iss_rd = 5'(k);
            tick();
            exp_busy[k] = 1'b1;
            check_eq($sformatf("cnt_full_x%0d", k), busy_cnt, $countones(exp_busy));
        end
        iss_rd = 5'd0;
        tick();
        idle();
        rd_addr = {5'd31, 5'd0};
        #1;
        check_eq("cnt_iss_x0", busy_cnt, 31);
        check_eq("busy_x0_x31", rd_busy, 2'b10);

        // Drain: two commits per cycle
        for (int k = 1; k < 32; k += 2) begin
            wr_en = 2'b11;
            wr_addr = {5'(k + 1), 5'(k)};
            wr_data = {32'(k + 1), 32'(k)};
            tick();
        end
        idle();
        rd_addr = {5'd31, 5'd16};
        #1;
        check_eq("cnt_drained", busy_cnt, 0);
        check_eq("busy_drained", rd_busy, 0);
        check_eq("data_x16", rd_data[31:0], 16);
        check_eq("data_x31", rd_data[63:32], 31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog: the directed sequence is a few hundred cycles at most.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
